// File: rtl/memory_control.sv
// Multi-cycle memory-access controller: a Moore FSM that sequences fetch, decode,
// address, access and write-back, driving strobes from the registered state and latched opcode.
module memory_control #(
  parameter int OPW = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           run,
  input  logic [OPW-1:0] opcode,
  output logic [1:0]     MemSrc,
  output logic           MemRead,
  output logic           MemWrite,
  output logic [2:0]     MemDst,
  output logic           MaryWrite,
  output logic           ShelleyWrite,
  output logic           CompWrite,
  output logic           RAWrite,
  output logic [1:0]     MarySrc,
  output logic [1:0]     ShelleySrc,
  output logic           IRWrite,
  output logic           PCWrite,
  output logic           SPWrite,
  output logic           SPDec,
  output logic           illegal,
  output logic [2:0]     state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    ADDR   = 3'd3,
    ACCESS = 3'd4,
    WB     = 3'd5
  } state_t;

  localparam logic [OPW-1:0] OP_NOP    = OPW'(0);
  localparam logic [OPW-1:0] OP_LDM    = OPW'(1);
  localparam logic [OPW-1:0] OP_LDS    = OPW'(2);
  localparam logic [OPW-1:0] OP_STM    = OPW'(3);
  localparam logic [OPW-1:0] OP_STS    = OPW'(4);
  localparam logic [OPW-1:0] OP_PUSHRA = OPW'(5);
  localparam logic [OPW-1:0] OP_POPRA  = OPW'(6);
  localparam logic [OPW-1:0] OP_LDC    = OPW'(7);

  localparam logic [1:0] SRC_PC  = 2'b00;
  localparam logic [1:0] SRC_SP  = 2'b01;
  localparam logic [1:0] SRC_REG = 2'b10;

  localparam logic [2:0] DST_NONE    = 3'b000;
  localparam logic [2:0] DST_MARY    = 3'b001;
  localparam logic [2:0] DST_SHELLEY = 3'b010;
  localparam logic [2:0] DST_COMP    = 3'b011;
  localparam logic [2:0] DST_RA      = 3'b100;

  state_t         stateQ;
  state_t         stateD;
  logic [OPW-1:0] opQ;

  // Classification of the latched opcode; drives every output.
  logic isLoad;
  logic isStore;
  logic isPush;
  logic isPop;
  logic opQIllegal;
  logic [1:0] addrSel;
  logic [2:0] dstSel;

  // Classification of the live opcode; used only for the DECODE branch.
  logic liveShort;
  state_t boundaryNext;

  assign isLoad     = (opQ == OP_LDM) || (opQ == OP_LDS) || (opQ == OP_LDC);
  assign isStore    = (opQ == OP_STM) || (opQ == OP_STS);
  assign isPush     = (opQ == OP_PUSHRA);
  assign isPop      = (opQ == OP_POPRA);
  assign opQIllegal = (opQ > OP_LDC);

  assign liveShort    = (opcode == OP_NOP) || (opcode > OP_LDC);
  assign boundaryNext = run ? FETCH : IDLE;

  always_comb begin
    addrSel = SRC_PC;
    if (isPush || isPop) begin
      addrSel = SRC_SP;
    end else if (isLoad || isStore) begin
      addrSel = SRC_REG;
    end
  end

  always_comb begin
    dstSel = DST_NONE;
    case (opQ)
      OP_LDM, OP_STM:       dstSel = DST_MARY;
      OP_LDS, OP_STS:       dstSel = DST_SHELLEY;
      OP_LDC:               dstSel = DST_COMP;
      OP_PUSHRA, OP_POPRA:  dstSel = DST_RA;
      default:              dstSel = DST_NONE;
    endcase
  end

  // op_q is also captured leaving FETCH so the DECODE-cycle illegal pulse is a
  // pure register decode; the DECODE capture is the one the instruction uses.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ <= IDLE;
      opQ    <= '0;
    end else begin
      stateQ <= stateD;
      if ((stateQ == FETCH) || (stateQ == DECODE)) begin
        opQ <= opcode;
      end
    end
  end

  always_comb begin
    stateD = IDLE;
    case (stateQ)
      IDLE:    stateD = run ? FETCH : IDLE;
      FETCH:   stateD = DECODE;
      DECODE:  stateD = liveShort ? boundaryNext : ADDR;
      ADDR:    stateD = ACCESS;
      ACCESS:  stateD = isStore ? boundaryNext : WB;
      WB:      stateD = boundaryNext;
      default: stateD = IDLE;
    endcase
  end

  always_comb begin
    MemSrc       = SRC_PC;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    MemDst       = DST_NONE;
    MaryWrite    = 1'b0;
    ShelleyWrite = 1'b0;
    CompWrite    = 1'b0;
    RAWrite      = 1'b0;
    MarySrc      = 2'b00;
    ShelleySrc   = 2'b00;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    SPWrite      = 1'b0;
    SPDec        = 1'b0;
    illegal      = 1'b0;
    case (stateQ)
      FETCH: begin
        MemSrc  = SRC_PC;
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      DECODE: begin
        illegal = opQIllegal;
      end
      ADDR: begin
        MemSrc  = addrSel;
        SPWrite = isPop;
      end
      ACCESS: begin
        MemSrc   = addrSel;
        MemDst   = dstSel;
        MemRead  = isLoad || isPop;
        MemWrite = isStore || isPush;
      end
      WB: begin
        MemDst = dstSel;
        case (opQ)
          OP_LDM: begin
            MaryWrite = 1'b1;
            MarySrc   = 2'b01;
          end
          OP_LDS: begin
            ShelleyWrite = 1'b1;
            ShelleySrc   = 2'b01;
          end
          OP_LDC:    CompWrite = 1'b1;
          OP_POPRA:  RAWrite   = 1'b1;
          OP_PUSHRA: begin
            SPWrite = 1'b1;
            SPDec   = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign state = stateQ;

endmodule

// File: tb/tb_memory_control.sv
// Directed plus randomized instruction stream against a per-instruction reference
// model that lists the expected output vector for every cycle of each opcode.
module tb_memory_control;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] memSrc;
    logic       memRead;
    logic       memWrite;
    logic [2:0] memDst;
    logic       maryWrite;
    logic       shelleyWrite;
    logic       compWrite;
    logic       raWrite;
    logic [1:0] marySrc;
    logic [1:0] shelleySrc;
    logic       irWrite;
    logic       pcWrite;
    logic       spWrite;
    logic       spDec;
    logic       illegal;
  } outs_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [3:0] opcode = '0;

  logic [1:0] MemSrc;
  logic       MemRead, MemWrite;
  logic [2:0] MemDst;
  logic       MaryWrite, ShelleyWrite, CompWrite, RAWrite;
  logic [1:0] MarySrc, ShelleySrc;
  logic       IRWrite, PCWrite, SPWrite, SPDec, illegal;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  outs_t exp_q[$];

  memory_control #(.OPW(4)) dut (
    .clock(clock), .reset(reset), .run(run), .opcode(opcode),
    .MemSrc(MemSrc), .MemRead(MemRead), .MemWrite(MemWrite), .MemDst(MemDst),
    .MaryWrite(MaryWrite), .ShelleyWrite(ShelleyWrite), .CompWrite(CompWrite),
    .RAWrite(RAWrite), .MarySrc(MarySrc), .ShelleySrc(ShelleySrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .SPWrite(SPWrite), .SPDec(SPDec),
    .illegal(illegal), .state(state)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic outs_t observed();
    return {state, MemSrc, MemRead, MemWrite, MemDst, MaryWrite, ShelleyWrite,
            CompWrite, RAWrite, MarySrc, ShelleySrc, IRWrite, PCWrite, SPWrite,
            SPDec, illegal};
  endfunction

  task automatic check_vec(input string tag, input outs_t expv);
    outs_t act;
    act = observed();
    checks++;
    assert (act === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, act, expv);
    end
    checks++;
    assert (!(MemRead && MemWrite) &&
            ($countones({MaryWrite, ShelleyWrite, CompWrite, RAWrite}) <= 1)) else begin
      errors++;
      $error("FAIL %s_exclusive observed=%h expected=no overlap", tag, act);
    end
  endtask

  // Reference model: the cycle-by-cycle output vectors of one instruction.
  function automatic void build(input logic [3:0] op);
    outs_t v;
    bit load, store, push, pop;
    logic [2:0] dst;
    logic [1:0] src;
    load  = (op == 1) || (op == 2) || (op == 7);
    store = (op == 3) || (op == 4);
    push  = (op == 5);
    pop   = (op == 6);
    case (op)
      1, 3:    dst = 3'b001;
      2, 4:    dst = 3'b010;
      7:       dst = 3'b011;
      5, 6:    dst = 3'b100;
      default: dst = 3'b000;
    endcase
    src = (push || pop) ? 2'b01 : 2'b10;

    v = '0; v.st = 3'd1; v.memRead = 1; v.irWrite = 1; v.pcWrite = 1;
    exp_q.push_back(v);
    v = '0; v.st = 3'd2; v.illegal = (op >= 8);
    exp_q.push_back(v);
    if (op == 0 || op >= 8) return;
    v = '0; v.st = 3'd3; v.memSrc = src; v.spWrite = pop;
    exp_q.push_back(v);
    v = '0; v.st = 3'd4; v.memSrc = src; v.memDst = dst;
    v.memRead = load || pop; v.memWrite = store || push;
    exp_q.push_back(v);
    if (store) return;
    v = '0; v.st = 3'd5; v.memDst = dst;
    case (op)
      1: begin v.maryWrite = 1; v.marySrc = 2'b01; end
      2: begin v.shelleyWrite = 1; v.shelleySrc = 2'b01; end
      7: v.compWrite = 1;
      6: v.raWrite = 1;
      5: begin v.spWrite = 1; v.spDec = 1; end
      default: ;
    endcase
    exp_q.push_back(v);
  endfunction

  // Called positioned in FETCH; leaves the DUT in FETCH (runNext) or IDLE.
  task automatic do_instr(input logic [3:0] op, input bit runNext, input bit scramble);
    int n;
    opcode = op;
    exp_q.delete();
    build(op);
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_vec($sformatf("op%0h_c%0d", op, i), exp_q.pop_front());
      if (i == n - 1) run = runNext;
      if (scramble && i >= 2) opcode = 4'($urandom);
      step();
    end
    if (!runNext) check_vec($sformatf("op%0h_park", op), outs_t'(0));
  endtask

  task automatic resume(input int idleCycles);
    for (int i = 0; i < idleCycles; i++) begin
      step();
      check_vec("idle_hold", outs_t'(0));
    end
    run = 1'b1;
    step();
  endtask

  initial begin
    logic [3:0] op;
    bit rn, scr;

    reset = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 3; i++) begin
      opcode = 4'($urandom);
      step();
      check_vec("reset_hold", outs_t'(0));
    end
    reset = 1'b0;
    step();

    do_instr(4'h1, 1'b1, 1'b0);
    do_instr(4'h3, 1'b1, 1'b0);
    do_instr(4'h6, 1'b1, 1'b0);
    do_instr(4'h5, 1'b1, 1'b0);
    do_instr(4'hA, 1'b1, 1'b0);
    do_instr(4'h0, 1'b1, 1'b0);
    do_instr(4'h7, 1'b1, 1'b0);
    do_instr(4'h4, 1'b1, 1'b0);
    do_instr(4'h2, 1'b1, 1'b1);
    do_instr(4'h1, 1'b0, 1'b0);
    resume(2);

    for (int k = 0; k < 60; k++) begin
      op  = 4'($urandom_range(0, 15));
      scr = bit'($urandom_range(0, 1));
      rn  = ($urandom_range(0, 4) != 0);
      do_instr(op, rn, scr);
      if (!rn) resume($urandom_range(0, 2));
    end

    // Reset landing in the ACCESS cycle of a store.
    opcode = 4'h4;
    exp_q.delete();
    build(4'h4);
    for (int i = 0; i < 4; i++) begin
      check_vec($sformatf("sts_rst_c%0d", i), exp_q.pop_front());
      if (i < 3) step();
    end
    reset = 1'b1;
    step();
    check_vec("sts_rst_after", outs_t'(0));
    reset = 1'b0;
    step();
    exp_q.delete();
    build(4'h0);
    check_vec("sts_rst_refetch", exp_q.pop_front());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
